// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
// State encodings are fixed so that bit 1 always equals the accepted level.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'b00,
    ST_WAIT_H = 2'b01,
    ST_HIGH   = 2'b11,
    ST_WAIT_L = 2'b10
  } state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 5;
  localparam int DEFAULT_CNT_WIDTH       = 3;

  typedef struct packed {
    logic data;
    logic rise;
    logic fall;
  } out_s;

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw input in, clean level and edge pulses out.
// No handshake: button_in is a free-running level; outputs are registered levels/pulses.
interface button_debouncer_if;
  import button_debouncer_pkg::*;

  logic   button_in;
  logic   data_clean;
  logic   rise_pulse;
  logic   fall_pulse;
  state_e dbg_state;

  modport master (
    output button_in,
    input  data_clean,
    input  rise_pulse,
    input  fall_pulse,
    input  dbg_state
  );

  modport slave (
    input  button_in,
    output data_clean,
    output rise_pulse,
    output fall_pulse,
    output dbg_state
  );

endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for the asynchronous button input; resets to 0.
module button_debouncer_sync_2ff (
  input  logic clock,
  input  logic reset_debouncer,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clock or posedge reset_debouncer) begin
    if (reset_debouncer) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw button into a registered level plus one-cycle rise/fall pulses.
// A new level is accepted after DEBOUNCE_CYCLES+1 consecutive equal synchronized samples.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
  input  logic               clock,
  input  logic               reset_debouncer,
  button_debouncer_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s2;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  out_s                 out_q, out_d;

  button_debouncer_sync_2ff u_sync (
    .clock           (clock),
    .reset_debouncer (reset_debouncer),
    .d_i             (bus.button_in),
    .q_o             (s2)
  );

  always_ff @(posedge clock or posedge reset_debouncer) begin
    if (reset_debouncer) state_q <= ST_LOW;
    else                 state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset_debouncer) begin
    if (reset_debouncer) cnt_q <= '0;
    else                 cnt_q <= cnt_d;
  end

  always_ff @(posedge clock or posedge reset_debouncer) begin
    if (reset_debouncer) out_q <= '0;
    else                 out_q <= out_d;
  end

  // Pulses default low so each lasts exactly one cycle; the counter holds at
  // CNT_LAST on acceptance and is re-zeroed on the next WAIT entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d.data  = out_q.data;
    out_d.rise  = 1'b0;
    out_d.fall  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s2) begin
          state_d = ST_WAIT_H;
          cnt_d   = '0;
        end
      end
      ST_WAIT_H: begin
        if (!s2) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_HIGH;
          out_d.data = 1'b1;
          out_d.rise = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s2) begin
          state_d = ST_WAIT_L;
          cnt_d   = '0;
        end
      end
      ST_WAIT_L: begin
        if (s2) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_LOW;
          out_d.data = 1'b0;
          out_d.fall = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.data_clean = out_q.data;
  assign bus.rise_pulse = out_q.rise;
  assign bus.fall_pulse = out_q.fall;
  assign bus.dbg_state  = state_q;

endmodule
